bcp_engine: RTL and testbench

- Boolean-constraint-propagation stage directly downstream of the DPLL control FSM.
- On each new assignment (prop_var, prop_val), scans every clause that contains the now-false literal and evaluates it against the variable state table.
- Pushes unit implications onto the imply stack; flags a conflict when a clause is fully falsified.
- Reports busy/done so control can leave its BCP wait state.

---
 rtl/sat_pkg.sv | 27 ++
 rtl/clause_eval.sv | 40 ++++
 rtl/bcp_engine.sv | 135 +++++++++++++
 tb/tb_bcp_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/sat_pkg.sv
// Shared types and sizes for the SAT solver datapath.
// Literal slots pack as {valid, polarity, var}; var state packs as {assigned, value}.
package sat_pkg;
    localparam int VAR_BITS = 8;
    localparam int CLS_BITS = 10;
    localparam int LITS     = 3;

    typedef struct packed {
        logic                valid;
        logic                polarity;
        logic [VAR_BITS-1:0] vid;
    } lit_t;

    typedef struct packed {
        logic assigned;
        logic value;
    } var_state_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RANGE  = 3'd1,
        S_FETCH  = 3'd2,
        S_READV  = 3'd3,
        S_EVAL   = 3'd4,
        S_FINISH = 3'd5
    } bcp_state_e;
endpackage

// File: rtl/clause_eval.sv
// Combinational clause evaluator: classifies one clause as satisfied, conflicting or unit.
// Invalid slots take no part in the classification.
module clause_eval
    import sat_pkg::*;
(
    input  lit_t       [LITS-1:0] i_lits,
    input  var_state_t [LITS-1:0] i_vst,
    output logic                  o_sat,
    output logic                  o_conflict,
    output logic                  o_unit,
    output logic [VAR_BITS-1:0]   o_unit_var,
    output logic                  o_unit_val
);
    localparam int NF_BITS = $clog2(LITS + 1);

    logic [NF_BITS-1:0] w_nfree;
    logic               w_any_true;

    always_comb begin
        w_any_true = 1'b0;
        w_nfree    = '0;
        o_unit_var = '0;
        o_unit_val = 1'b0;
        for (int s = 0; s < LITS; s++) begin
            if (i_lits[s].valid) begin
                if (i_vst[s].assigned && (i_vst[s].value == i_lits[s].polarity))
                    w_any_true = 1'b1;
                if (!i_vst[s].assigned) begin
                    w_nfree    = w_nfree + NF_BITS'(1);
                    o_unit_var = i_lits[s].vid;
                    o_unit_val = i_lits[s].polarity;
                end
            end
        end
    end

    assign o_sat      = w_any_true;
    assign o_conflict = !w_any_true && (w_nfree == '0);
    assign o_unit     = !w_any_true && (w_nfree == NF_BITS'(1));
endmodule

// File: rtl/bcp_engine.sv
// Boolean constraint propagation: walks the occurrence list of the newly falsified
// literal, pushing unit implications and stopping at the first falsified clause.
module bcp_engine
    import sat_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [VAR_BITS-1:0]      prop_var,
    input  logic                     prop_val,
    output logic [VAR_BITS:0]        occ_addr,
    input  logic [CLS_BITS-1:0]      occ_start,
    input  logic [CLS_BITS:0]        occ_count,
    output logic [CLS_BITS-1:0]      cls_addr,
    input  logic [LITS*(VAR_BITS+2)-1:0] cls_lit,
    output logic [LITS*VAR_BITS-1:0] vst_addr,
    input  logic [LITS*2-1:0]        vst_data,
    output logic                     imply_push,
    output logic [VAR_BITS-1:0]      imply_var,
    output logic                     imply_val,
    output logic                     imply_type,
    input  logic                     imply_full,
    output logic                     conflict,
    output logic                     busy,
    output logic                     done
);
    bcp_state_e             r_state;
    logic [VAR_BITS:0]      r_occ_addr;
    logic [CLS_BITS-1:0]    r_idx;
    logic [CLS_BITS:0]      r_rem;
    lit_t       [LITS-1:0]  r_lits;
    logic                   r_busy, r_done, r_conflict, r_push, r_ival;
    logic [VAR_BITS-1:0]    r_ivar;

    lit_t       [LITS-1:0]  w_lits_in;
    var_state_t [LITS-1:0]  w_vst;
    logic                   w_sat, w_conflict, w_unit, w_uval;
    logic [VAR_BITS-1:0]    w_uvar;

    assign w_lits_in = cls_lit;
    assign w_vst     = vst_data;

    clause_eval u_eval (
        .i_lits     (r_lits),
        .i_vst      (w_vst),
        .o_sat      (w_sat),
        .o_conflict (w_conflict),
        .o_unit     (w_unit),
        .o_unit_var (w_uvar),
        .o_unit_val (w_uval)
    );

    // Occurrence table has one cycle of latency, so the address is presented with start.
    assign occ_addr = (start && r_state == S_IDLE) ? {prop_var, ~prop_val} : r_occ_addr;
    assign cls_addr = (r_state == S_FETCH) ? r_idx : '0;

    // Re-present slot addresses during EVAL so var state stays valid across a stall.
    always_comb begin
        vst_addr = '0;
        for (int s = 0; s < LITS; s++) begin
            if (r_state == S_READV)
                vst_addr[s*VAR_BITS +: VAR_BITS] = w_lits_in[s].vid;
            else if (r_state == S_EVAL)
                vst_addr[s*VAR_BITS +: VAR_BITS] = r_lits[s].vid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_occ_addr <= '0;
            r_idx      <= '0;
            r_rem      <= '0;
            r_lits     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
            r_push     <= 1'b0;
            r_ivar     <= '0;
            r_ival     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_conflict <= 1'b0;
            r_push     <= 1'b0;
            r_ivar     <= '0;
            r_ival     <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_occ_addr <= {prop_var, ~prop_val};
                    r_busy     <= 1'b1;
                    r_state    <= S_RANGE;
                end
                S_RANGE: begin
                    r_idx   <= occ_start;
                    r_rem   <= occ_count;
                    r_state <= (occ_count == '0) ? S_FINISH : S_FETCH;
                end
                S_FETCH: r_state <= S_READV;
                S_READV: begin
                    r_lits  <= w_lits_in;
                    r_state <= S_EVAL;
                end
                S_EVAL: begin
                    if (!w_sat && w_conflict) begin
                        r_conflict <= 1'b1;
                        r_state    <= S_FINISH;
                    end else if (!(!w_sat && w_unit && imply_full)) begin
                        if (!w_sat && w_unit) begin
                            r_push <= 1'b1;
                            r_ivar <= w_uvar;
                            r_ival <= w_uval;
                        end
                        r_idx   <= r_idx + CLS_BITS'(1);
                        r_rem   <= r_rem - (CLS_BITS+1)'(1);
                        r_state <= (r_rem == (CLS_BITS+1)'(1)) ? S_FINISH : S_FETCH;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imply_push = r_push;
    assign imply_var  = r_ivar;
    assign imply_val  = r_ival;
    assign imply_type = 1'b1;
    assign conflict   = r_conflict;
    assign busy       = r_busy;
    assign done       = r_done;
endmodule

// File: tb/tb_bcp_engine.sv
// Directed scoreboard bench for bcp_engine with synchronous-read memory models.
module tb_bcp_engine;
    import sat_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  prop_var = '0;
    logic        prop_val = 1'b0;
    logic [8:0]  occ_addr;
    logic [9:0]  occ_start;
    logic [10:0] occ_count;
    logic [9:0]  cls_addr;
    logic [29:0] cls_lit;
    logic [23:0] vst_addr;
    logic [5:0]  vst_data;
    logic        imply_push, imply_val, imply_type, conflict, busy, done;
    logic [7:0]  imply_var;
    logic        imply_full = 1'b0;

    bcp_engine dut (
        .clock(clock), .reset(reset), .start(start), .prop_var(prop_var), .prop_val(prop_val),
        .occ_addr(occ_addr), .occ_start(occ_start), .occ_count(occ_count),
        .cls_addr(cls_addr), .cls_lit(cls_lit), .vst_addr(vst_addr), .vst_data(vst_data),
        .imply_push(imply_push), .imply_var(imply_var), .imply_val(imply_val),
        .imply_type(imply_type), .imply_full(imply_full), .conflict(conflict),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    logic [9:0]  occ_st_m [512];
    logic [10:0] occ_ct_m [512];
    logic [29:0] cls_m    [1024];
    logic [1:0]  vst_m    [256];

    always @(posedge clock) begin
        occ_start <= occ_st_m[occ_addr];
        occ_count <= occ_ct_m[occ_addr];
        cls_lit   <= cls_m[cls_addr];
        for (int s = 0; s < 3; s++) vst_data[s*2 +: 2] <= vst_m[vst_addr[s*8 +: 8]];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int hits201 = 0;
    always @(negedge clock) if (cls_addr == 10'd201) hits201 <= hits201 + 1;

    typedef struct { int kind; int v; int val; int cyc; } ev_t;  // kind: 0 push, 1 conflict, 2 done
    ev_t sb[$];
    int n_vec = 0;
    int n_fail = 0;

    always @(negedge clock) begin
        if (!reset && (imply_push || conflict || done)) begin
            int k;
            ev_t e;
            k = imply_push ? 0 : (conflict ? 1 : 2);
            n_vec++;
            if (imply_push && conflict) begin
                n_fail++;
                $display("FAIL push_conflict_overlap cyc=%0d", cyc);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event cyc=%0d kind=%0d var=%0d val=%0d", cyc, k, imply_var, imply_val);
            end else begin
                e = sb.pop_front();
                if (k != e.kind || cyc != e.cyc ||
                    (k == 0 && (int'(imply_var) != e.v || int'(imply_val) != e.val || imply_type !== 1'b1))) begin
                    n_fail++;
                    $display("FAIL event got kind=%0d var=%0d val=%0d type=%0d cyc=%0d exp kind=%0d var=%0d val=%0d cyc=%0d",
                             k, imply_var, imply_val, imply_type, cyc, e.kind, e.v, e.val, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [9:0] L(input bit v, input bit p, input int x);
        logic [7:0] id;
        id = x[7:0];
        return {v, p, id};
    endfunction

    task automatic set_occ(input int v, input int pol, input int st, input int cnt);
        occ_st_m[v*2+pol] = st[9:0];
        occ_ct_m[v*2+pol] = cnt[10:0];
    endtask

    task automatic expect_ev(input int kind, input int v, input int val, input int c);
        ev_t e;
        e.kind = kind; e.v = v; e.val = val; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic go(input int v, input bit val, output int st);
        @(negedge clock);
        start = 1'b1; prop_var = v[7:0]; prop_val = val; st = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!done && k < 60) begin @(negedge clock); k++; end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL %s_timeout got=no_done exp=done", nm);
        end
        @(negedge clock);
        chk({nm, "_sb_drained"}, sb.size(), 0);
        chk({nm, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int st;
        int h0;
        for (int i = 0; i < 512; i++) begin occ_st_m[i] = '0; occ_ct_m[i] = '0; end
        for (int i = 0; i < 1024; i++) cls_m[i] = '0;
        for (int i = 0; i < 256; i++) vst_m[i] = '0;
        vst_m[5] = 2'b11; vst_m[9] = 2'b10;

        cls_m[100] = {L(1,1,9), L(1,1,7), L(1,0,5)};
        cls_m[200] = {L(0,0,0), L(1,1,7), L(1,0,5)};
        cls_m[201] = {L(0,0,0), L(1,1,13), L(1,0,5)};
        cls_m[300] = {L(0,0,0), L(1,0,9), L(1,0,5)};
        cls_m[301] = cls_m[100];
        cls_m[302] = cls_m[300];
        cls_m[400] = {L(0,0,0), L(1,0,9), L(1,0,5)};
        cls_m[401] = {L(1,1,11), L(1,1,7), L(1,0,5)};
        cls_m[402] = {L(1,1,9), L(1,0,3), L(1,0,5)};

        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_push", imply_push, 0);
        chk("rst_ivar", imply_var, 0);
        chk("rst_ival", imply_val, 0);
        chk("rst_occ_addr", occ_addr, 0);
        chk("rst_cls_addr", cls_addr, 0);
        chk("rst_vst_addr", vst_addr, 0);
        reset = 1'b0;

        // empty list
        set_occ(5, 0, 0, 0);
        go(5, 1'b1, st);
        chk("empty_occ_addr", dut.r_occ_addr, 9'd10);
        expect_ev(2, 0, 0, st + 3);
        wait_done("empty");

        // single unit clause
        set_occ(5, 0, 100, 1);
        go(5, 1'b1, st);
        chk("unit_busy", busy, 1);
        expect_ev(0, 7, 1, st + 5);
        expect_ev(2, 0, 0, st + 6);
        wait_done("unit");

        // conflict stops the scan before the second clause
        vst_m[7] = 2'b10;
        set_occ(5, 0, 200, 2);
        h0 = hits201;
        go(5, 1'b1, st);
        expect_ev(1, 0, 0, st + 5);
        expect_ev(2, 0, 0, st + 6);
        wait_done("conflict");
        chk("conflict_no_fetch201", hits201, h0);
        vst_m[7] = 2'b00;

        // backpressure on the imply stack
        set_occ(5, 0, 100, 1);
        imply_full = 1'b1;
        go(5, 1'b1, st);
        while (cyc < st + 8) @(negedge clock);
        chk("bp_busy_stalled", busy, 1);
        chk("bp_no_push_yet", sb.size(), 0);
        expect_ev(0, 7, 1, st + 9);
        expect_ev(2, 0, 0, st + 10);
        imply_full = 1'b0;
        wait_done("backpressure");

        // reset during EVAL of the second clause
        set_occ(5, 0, 300, 3);
        go(5, 1'b1, st);
        while (cyc < st + 7) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_push", imply_push, 0);
        chk("mid_rst_conflict", conflict, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_occ_addr", occ_addr, 0);
        chk("mid_rst_vst_addr", vst_addr, 0);
        chk("mid_rst_state", dut.r_state, S_IDLE);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        set_occ(5, 0, 100, 1);
        go(5, 1'b1, st);
        expect_ev(0, 7, 1, st + 5);
        expect_ev(2, 0, 0, st + 6);
        wait_done("after_reset");

        // mixed list: satisfied, two free, unit
        set_occ(5, 0, 400, 3);
        go(5, 1'b1, st);
        expect_ev(0, 3, 0, st + 11);
        expect_ev(2, 0, 0, st + 12);
        wait_done("mixed");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
